// File: rtl/pcap_replay_pacer_if.sv
// AXI4-Stream beat bundle shared by both sides of the pacer.
// The master drives the payload and tvalid. The slave drives tready.
interface pcap_replay_pacer_if #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned USER_W = 128
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] tdata;
  logic [STRB_W-1:0] tstrb;
  logic [USER_W-1:0] tuser;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/pcap_replay_pacer.sv
// Pacing stage for the pcap replay stream: one-beat output register, a programmable
// idle gap after each packet, an enable gate on packet starts, and an emitted-packet counter.
module pcap_replay_pacer #(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned DELAY_WIDTH          = 32,
  parameter int unsigned PKT_COUNT_WIDTH      = 32
) (
  input  logic                       axi_aclk,
  input  logic                       axi_aresetn,
  pcap_replay_pacer_if.slave         s_axis,
  pcap_replay_pacer_if.master        m_axis,
  input  logic                       sw_rst,
  input  logic                       enable,
  input  logic [DELAY_WIDTH-1:0]     ipg_cycles,
  output logic [PKT_COUNT_WIDTH-1:0] pkt_count,
  output logic                       gap_active
);

  localparam int unsigned M_STRB_W = C_M_AXIS_DATA_WIDTH / 8;
  localparam int unsigned S_STRB_W = C_S_AXIS_DATA_WIDTH / 8;

  localparam logic [0:0] ST_PASS = 1'b0;
  localparam logic [0:0] ST_GAP  = 1'b1;

  typedef struct packed {
    logic [C_M_AXIS_DATA_WIDTH-1:0]  data;
    logic [M_STRB_W-1:0]             strb;
    logic [C_M_AXIS_TUSER_WIDTH-1:0] user;
    logic                            last;
  } beat_t;

  logic                            rst_c;
  logic                            s_ready_c;
  logic                            in_hs_c;
  logic                            out_hs_c;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  s_data_c;
  logic [S_STRB_W-1:0]             s_strb_c;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_user_c;
  beat_t                           s_beat_c;

  logic [0:0]                 state_q,      state_d;
  logic [DELAY_WIDTH-1:0]     gap_cnt_q,    gap_cnt_d;
  logic                       gap_active_q, gap_active_d;
  logic                       in_pkt_q,     in_pkt_d;
  logic                       m_valid_q,    m_valid_d;
  beat_t                      beat_q,       beat_d;
  logic [PKT_COUNT_WIDTH-1:0] pkt_count_q,  pkt_count_d;

  // Slave payload, resized onto the master-side beat layout
  always_comb begin
    s_data_c      = s_axis.tdata;
    s_strb_c      = s_axis.tstrb;
    s_user_c      = s_axis.tuser;
    s_beat_c.data = C_M_AXIS_DATA_WIDTH'(s_data_c);
    s_beat_c.strb = M_STRB_W'(s_strb_c);
    s_beat_c.user = C_M_AXIS_TUSER_WIDTH'(s_user_c);
    s_beat_c.last = s_axis.tlast;
  end

  // A packet already in flight ignores enable; only its first beat is gated
  always_comb begin
    rst_c     = !axi_aresetn || sw_rst;
    s_ready_c = !rst_c && (state_q == ST_PASS) && (in_pkt_q || enable) &&
                (!m_valid_q || m_axis.tready);
    in_hs_c   = s_axis.tvalid && s_ready_c;
    out_hs_c  = m_valid_q && m_axis.tready;
  end

  // Next state: pacing FSM, packet tracking, output register and counter
  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    gap_active_d = gap_active_q;
    in_pkt_d     = in_pkt_q;
    m_valid_d    = m_valid_q;
    beat_d       = beat_q;
    pkt_count_d  = pkt_count_q;

    case (state_q)
      ST_PASS: begin
        if (in_hs_c && s_axis.tlast && (ipg_cycles != '0)) begin
          state_d      = ST_GAP;
          gap_cnt_d    = ipg_cycles;
          gap_active_d = 1'b1;
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - DELAY_WIDTH'(1);
        if (gap_cnt_q <= DELAY_WIDTH'(1)) begin
          state_d      = ST_PASS;
          gap_active_d = 1'b0;
        end
      end
      default: begin
        state_d      = ST_PASS;
        gap_active_d = 1'b0;
      end
    endcase

    if (in_hs_c) begin
      in_pkt_d = !s_axis.tlast;
    end

    // A new beat overwrites the register in the same cycle the old one leaves
    if (in_hs_c) begin
      beat_d    = s_beat_c;
      m_valid_d = 1'b1;
    end else if (out_hs_c) begin
      m_valid_d = 1'b0;
    end

    if (out_hs_c && beat_q.last) begin
      pkt_count_d = pkt_count_q + PKT_COUNT_WIDTH'(1);
    end
  end

  // State register; the software reset clears the same state as the bus reset
  always_ff @(posedge axi_aclk) begin
    if (rst_c) begin
      state_q      <= ST_PASS;
      gap_cnt_q    <= '0;
      gap_active_q <= 1'b0;
      in_pkt_q     <= 1'b0;
      m_valid_q    <= 1'b0;
      beat_q       <= '0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      gap_active_q <= gap_active_d;
      in_pkt_q     <= in_pkt_d;
      m_valid_q    <= m_valid_d;
      beat_q       <= beat_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign s_axis.tready = s_ready_c;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tdata  = beat_q.data;
  assign m_axis.tstrb  = beat_q.strb;
  assign m_axis.tuser  = beat_q.user;
  assign m_axis.tlast  = beat_q.last;
  assign pkt_count     = pkt_count_q;
  assign gap_active    = gap_active_q;

endmodule

// File: tb/tb_pcap_replay_pacer.sv
// Scoreboard bench for pcap_replay_pacer: directed scenarios followed by randomized traffic.
// Expectations come from a packet/gap model kept here.
module tb_pcap_replay_pacer;
  localparam int unsigned DW  = 256;
  localparam int unsigned UW  = 128;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned DLW = 8;
  localparam int unsigned PCW = 4;

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  logic           clk = 1'b0;
  logic           rstn;
  logic           sw_rst;
  logic           enable;
  logic [DLW-1:0] ipg;
  logic [PCW-1:0] pkt_count;
  logic           gap_active;

  pcap_replay_pacer_if #(.DATA_W(DW), .USER_W(UW)) s_if ();
  pcap_replay_pacer_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

  pcap_replay_pacer #(
    .C_M_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_M_AXIS_TUSER_WIDTH(UW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .DELAY_WIDTH         (DLW),
    .PKT_COUNT_WIDTH     (PCW)
  ) dut (
    .axi_aclk   (clk),
    .axi_aresetn(rstn),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .sw_rst     (sw_rst),
    .enable     (enable),
    .ipg_cycles (ipg),
    .pkt_count  (pkt_count),
    .gap_active (gap_active)
  );

  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  beat_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Input-side model: packet state and gap window from the rules, plus scoreboard pushes
  int gap_end  = -1;
  bit in_pkt_m = 1'b0;
  bit exp_gap;
  always @(negedge clk) begin
    #2;
    if (!rstn || sw_rst) begin
      gap_end  = cyc;
      in_pkt_m = 1'b0;
    end else begin
      exp_gap = (cyc <= gap_end);
      chk(gap_active == exp_gap, "gap_active", DW'(gap_active), DW'(exp_gap));
      if (exp_gap)
        chk(!s_if.tready, "tready_in_gap", DW'(s_if.tready), 0);
      else if (!in_pkt_m && !enable)
        chk(!s_if.tready, "tready_enable_gate", DW'(s_if.tready), 0);
      else if (m_if.tready)
        chk(s_if.tready, "tready_open", DW'(s_if.tready), 1);
      if (s_if.tvalid && s_if.tready) begin
        exp_q.push_back('{d: s_if.tdata, s: s_if.tstrb, u: s_if.tuser, l: s_if.tlast});
        in_pkt_m = !s_if.tlast;
        if (s_if.tlast && ipg != '0) gap_end = cyc + int'(ipg);
      end
    end
  end

  // Output-side monitor: pops the scoreboard on each output handshake
  logic [PCW-1:0] exp_cnt  = '0;
  bit             prev_rst = 1'b0;
  bit             seen_rst = 1'b0;
  bit             prev_stall = 1'b0;
  bit             cur_rst;
  beat_t          prev_b;
  beat_t          e;
  always @(negedge clk) begin
    #2;
    cur_rst = !rstn || sw_rst;
    if (prev_rst) begin
      chk(!m_if.tvalid, "rst_tvalid", DW'(m_if.tvalid), 0);
      chk(pkt_count == '0, "rst_pkt_count", DW'(pkt_count), 0);
      chk(!gap_active, "rst_gap_active", DW'(gap_active), 0);
    end else if (seen_rst) begin
      chk(pkt_count == exp_cnt, "pkt_count", DW'(pkt_count), DW'(exp_cnt));
    end
    if (prev_stall && !prev_rst) begin
      chk(m_if.tvalid, "stall_tvalid", DW'(m_if.tvalid), 1);
      chk(m_if.tdata == prev_b.d && m_if.tstrb == prev_b.s && m_if.tuser == prev_b.u &&
          m_if.tlast == prev_b.l, "stall_hold", m_if.tdata, prev_b.d);
    end
    if (cur_rst) begin
      exp_q.delete();
      exp_cnt = '0;
    end else if (m_if.tvalid && m_if.tready) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_beat", m_if.tdata, 0);
      end else begin
        e = exp_q.pop_front();
        chk(m_if.tdata == e.d, "out_tdata", m_if.tdata, e.d);
        chk({m_if.tstrb, m_if.tuser, m_if.tlast} == {e.s, e.u, e.l}, "out_strb_user_last",
            DW'({m_if.tstrb, m_if.tuser, m_if.tlast}), DW'({e.s, e.u, e.l}));
      end
      if (m_if.tlast) exp_cnt = exp_cnt + PCW'(1);
    end
    prev_stall = !cur_rst && m_if.tvalid && !m_if.tready;
    prev_b     = '{d: m_if.tdata, s: m_if.tstrb, u: m_if.tuser, l: m_if.tlast};
    if (cur_rst) seen_rst = 1'b1;
    prev_rst = cur_rst;
  end

  // Stimulus driver
  bit             rand_mode  = 1'b0;
  bit             toggle_rdy = 1'b0;
  bit             rdy_n      = 1'b0;
  bit             en_n       = 1'b0;
  bit             srst_n     = 1'b0;
  logic [DLW-1:0] ipg_n      = '0;
  bit             acc;

  function automatic beat_t rand_beat(input bit last);
    beat_t b;
    for (int i = 0; i < DW / 32; i++) b.d[i*32 +: 32] = $urandom();
    for (int i = 0; i < UW / 32; i++) b.u[i*32 +: 32] = $urandom();
    b.s = SW'($urandom());
    b.l = last;
    return b;
  endfunction

  task automatic tick(input bit v, input beat_t b);
    @(negedge clk);
    if (rand_mode) begin
      rdy_n  = ($urandom_range(3) != 0);
      en_n   = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) ipg_n = DLW'($urandom_range(9));
      srst_n = ($urandom_range(79) == 0);
      if (srst_n) rdy_n = 1'b0;
    end else if (toggle_rdy) begin
      rdy_n = !rdy_n;
    end
    m_if.tready = rdy_n;
    enable      = en_n;
    ipg         = ipg_n;
    sw_rst      = srst_n;
    s_if.tvalid = v;
    s_if.tdata  = b.d;
    s_if.tstrb  = b.s;
    s_if.tuser  = b.u;
    s_if.tlast  = b.l;
    #1;
    acc = v && s_if.tready;
  endtask

  task automatic send_beat(input beat_t b);
    int n = 0;
    do begin
      tick(1'b1, b);
      n++;
    end while (!acc && n < 200);
    chk(acc, "accept_timeout", DW'(acc), 1);
  endtask

  task automatic send_pkt(input int len);
    for (int i = 0; i < len; i++) begin
      if (rand_mode && $urandom_range(3) == 0) tick(1'b0, rand_beat(1'b0));
      send_beat(rand_beat(i == len - 1));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, rand_beat(1'b0));
  endtask

  beat_t hold_b;

  initial begin
    rstn = 1'b0; sw_rst = 1'b0; enable = 1'b0; ipg = '0;
    m_if.tready = 1'b0; s_if.tvalid = 1'b0; s_if.tdata = '0;
    s_if.tstrb = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    idle(2);

    // Back-to-back 2-beat packets with no gap
    rdy_n = 1'b1; en_n = 1'b1; ipg_n = '0;
    repeat (3) send_pkt(2);
    idle(3);

    // Five-cycle gap after a single-beat packet
    ipg_n = DLW'(5);
    send_pkt(1);
    send_pkt(1);
    idle(8);

    // Downstream ready toggling across a 6-beat packet
    ipg_n = '0; toggle_rdy = 1'b1;
    send_pkt(6);
    toggle_rdy = 1'b0; rdy_n = 1'b1;
    idle(4);

    // Enable dropped mid-packet: packet completes, next start waits
    send_beat(rand_beat(1'b0));
    en_n = 1'b0;
    send_beat(rand_beat(1'b0));
    send_beat(rand_beat(1'b0));
    send_beat(rand_beat(1'b1));
    hold_b = rand_beat(1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, hold_b);
      chk(!acc, "enable_blocks_start", DW'(acc), 0);
    end
    en_n = 1'b1;
    send_beat(hold_b);
    idle(3);

    // Software reset with a beat held in the output register
    send_beat(rand_beat(1'b0));
    send_beat(rand_beat(1'b0));
    rdy_n = 1'b0; srst_n = 1'b1;
    tick(1'b1, rand_beat(1'b0));
    chk(!acc, "no_accept_in_reset", DW'(acc), 0);
    srst_n = 1'b0; rdy_n = 1'b1;
    idle(1);
    send_pkt(2);
    idle(3);

    // Gap value changed mid-gap, then enough packets to wrap the counter
    ipg_n = DLW'(8);
    send_pkt(1);
    ipg_n = DLW'(2);
    repeat (16) send_pkt(1);
    idle(4);

    // Randomized traffic
    rand_mode = 1'b1;
    for (int p = 0; p < 40; p++) send_pkt(int'($urandom_range(6, 1)));
    rand_mode = 1'b0; rdy_n = 1'b1; en_n = 1'b1; srst_n = 1'b0;
    idle(20);
    chk(exp_q.size() == 0, "drain_empty", DW'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1);
  end

endmodule

// File: doc/pcap_replay_pacer.md
Name: pcap_replay_pacer

Overview:
- AXI4-Stream pacing stage directly downstream of the pcap replay micro-engine's master stream.
- Forwards replayed packets unchanged through a one-beat output register.
- Enforces a programmable idle gap, in clock cycles, between consecutive packets.
- Gates the start of new packets with an enable, and counts packets emitted toward the output queues.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, master tdata width (tstrb = width/8)
- C_S_AXIS_DATA_WIDTH, 256, slave tdata width; must equal C_M_AXIS_DATA_WIDTH
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width; must equal C_M_AXIS_TUSER_WIDTH
- DELAY_WIDTH, 32, width of the inter-packet gap value
- PKT_COUNT_WIDTH, 32, width of the emitted-packet counter

Ports:
Clocking and reset (already decided): one clock, axi_aclk; reset axi_aresetn is synchronous and active-low.
- axi_aclk  in  1  sole clock
- axi_aresetn  in  1  synchronous active-low reset
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  input beat data
- s_axis_tstrb  in  C_S_AXIS_DATA_WIDTH/8  byte strobes
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  metadata
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  last beat of packet
- m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  output data
- m_axis_tstrb  out  C_M_AXIS_DATA_WIDTH/8  output strobes
- m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  output metadata
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  output last
- sw_rst  in  1  software reset, active-high, same effect as axi_aresetn low
- enable  in  1  permit start of new packets
- ipg_cycles  in  DELAY_WIDTH  idle cycles inserted after each packet
- pkt_count  out  PKT_COUNT_WIDTH  packets completed on the m side
- gap_active  out  1  high while the gap counter is running

Behaviour:
- Reset condition = !axi_aresetn | sw_rst, sampled at the clock edge. In that cycle and on the following edge:
  - m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tuser and m_axis_tlast all go to 0.
  - pkt_count = 0, gap_active = 0, gap counter = 0, in_pkt = 0, state = PASS.
  - s_axis_tready is forced to 0 combinationally while the reset condition is true.
- Reset mid-packet drops the output beat and truncates the packet; no tlast is emitted for it.
- States:
  - PASS: beats may be accepted.
  - GAP: s_axis_tready = 0; the counter decrements by 1 per cycle.
- In PASS: s_axis_tready = (in_pkt | enable) & (!m_axis_tvalid | m_axis_tready).
  - enable only blocks the first beat of a packet; a packet already started always completes.
- Output register, latency 1 cycle:
  - On input handshake, load data, strb, user and last into the output register and set m_axis_tvalid = 1.
  - Else, on output handshake, clear m_axis_tvalid.
  - Full throughput (one beat per cycle) while m_axis_tready = 1.
  - Output fields stay stable while m_axis_tvalid & !m_axis_tready.
  - Simultaneous input and output handshakes replace the register contents; no bubble.
- in_pkt:
  - Set on input handshake with !s_axis_tlast.
  - Cleared on input handshake with s_axis_tlast.
  - A single-beat packet leaves in_pkt = 0.
- Input handshake with s_axis_tlast:
  - If ipg_cycles == 0: stay in PASS (back-to-back packets allowed).
  - Else: go to GAP, counter = ipg_cycles, gap_active = 1.
  - ipg_cycles is sampled only at this moment; changes during GAP have no effect.
- In GAP:
  - Counter decrements each cycle.
  - When counter == 1, next state = PASS and gap_active = 0.
  - Result: exactly ipg_cycles cycles with s_axis_tready low, counted from the cycle after tlast acceptance.
  - The gap is measured at the input side; downstream stalls do not extend or shorten it.
- pkt_count:
  - +1 on each output handshake with m_axis_tlast.
  - Wraps modulo 2^PKT_COUNT_WIDTH.
- tdata, tstrb and tuser pass bit-for-bit unmodified; the block performs no checking on them.

Test Plan:
1. ipg_cycles=0, enable=1, m_axis_tready=1, three 2-beat packets back-to-back -> identical beats appear 1 cycle later, no idle cycles, pkt_count=3.
2. ipg_cycles=5, tlast accepted at cycle t -> s_axis_tready=0 and gap_active=1 for cycles t+1..t+5; s_axis_tready=1 at t+6.
3. m_axis_tready pattern 1,0,1,0 across a 6-beat packet -> all 6 beats delivered in order, none duplicated, outputs stable during stalls, pkt_count=1.
4. enable dropped after beat 1 of a 4-beat packet -> beats 2-4 still accepted; next packet's first beat waits until enable=1.
5. sw_rst pulsed for 1 cycle mid-packet with m_axis_tvalid=1 -> next cycle m_axis_tvalid=0, pkt_count=0, gap_active=0; a new packet is accepted once sw_rst=0 and enable=1.
6. PKT_COUNT_WIDTH=4, ipg_cycles changed 8->2 during a gap, 16 single-beat packets -> the running gap lasts 8 cycles, later gaps last 2, pkt_count wraps to 0.
